// File: rtl/gate_motor_controller_pkg.sv
// Shared state codes, direction values and the registered output bundle
// for the gate motor sequencer and the HEX display decoder.
package gate_motor_controller_pkg;

  localparam logic [2:0] ST_CLOSED  = 3'd0;
  localparam logic [2:0] ST_OPENING = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_CLOSING = 3'd3;
  localparam logic [2:0] ST_STOPPED = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd5;

  localparam logic DIR_OPEN  = 1'b1;
  localparam logic DIR_CLOSE = 1'b0;

  typedef struct packed {
    logic motor;
    logic sentido;
    logic led_verde;
    logic led_vermelho;
  } drive_t;

  function automatic logic is_moving(input logic [2:0] st);
    return (st == ST_OPENING) || (st == ST_CLOSING);
  endfunction

endpackage

// File: rtl/gate_motor_controller_debounce_pulse.sv
// Button conditioner: 2-FF synchronizer, stable-level counter and a one-cycle
// pulse on each accepted rising level.
module debounce_pulse #(
  parameter int          CNT_W        = 30,
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'((DEBOUNCE_CYC == 0) ? 0 : DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [1:0]       sync;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) sync <= {sync[0], raw};

  // Level flips only after the synchronized input has disagreed with it for
  // DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      level_q <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/gate_motor_controller.sv
// Gate motor sequencer: button/limit/obstacle inputs to motor enable and
// direction, with auto-close, obstacle reversal, travel timeout and dead time.
module gate_motor_controller
  import gate_motor_controller_pkg::*;
#(
  parameter int          CNT_W          = 30,
  parameter int unsigned DEBOUNCE_CYC   = 500000,
  parameter int unsigned DEAD_CYC       = 50000,
  parameter int unsigned TRAVEL_CYC     = 250000000,
  parameter int unsigned AUTO_CLOSE_CYC = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       botao,
  input  logic       aberto,
  input  logic       fechado,
  input  logic       obstaculo,
  output logic       motor,
  output logic       sentido,
  output logic       led_verde,
  output logic       led_vermelho,
  output logic [2:0] estado
);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'((DEAD_CYC == 0) ? 0 : DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] TRAVEL_LIM = CNT_W'(TRAVEL_CYC);
  localparam logic [CNT_W-1:0] AUTO_LIM   = CNT_W'(AUTO_CLOSE_CYC);
  localparam logic             DEAD_SKIP  = (DEAD_CYC == 0);

  // Reset asserts asynchronously, releases two clocks later.
  logic [1:0] rst_q;
  logic       rst_sync_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= '0;
    else        rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_sync_n = rst_q[1];

  // Sensor synchronizers run through reset so limits are valid at release.
  logic [1:0] ab_q, fe_q, ob_q;
  logic       aberto_s, fechado_s, obst_s, btn_pulse;
  always_ff @(posedge clk) begin
    ab_q <= {ab_q[0], aberto};
    fe_q <= {fe_q[0], fechado};
    ob_q <= {ob_q[0], obstaculo};
  end
  assign aberto_s  = ab_q[1];
  assign fechado_s = fe_q[1];
  assign obst_s    = ob_q[1];

  debounce_pulse #(.CNT_W(CNT_W), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .clk   (clk),
    .rst_n (rst_sync_n),
    .raw   (botao),
    .pulse (btn_pulse)
  );

  logic [2:0]       state, state_n;
  logic             last_dir, last_dir_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             dead, dead_n;
  logic             travel_to, motor_n;
  drive_t           drv, drv_n;

  assign cnt_inc   = (cnt == '1) ? cnt : cnt + ONE;
  assign travel_to = dead && (cnt == TRAVEL_LIM);

  always_comb begin
    state_n    = state;
    last_dir_n = last_dir;
    if (state != ST_FAULT && aberto_s && fechado_s) begin
      state_n = ST_FAULT;
    end else begin
      case (state)
        ST_CLOSED:  if (btn_pulse) state_n = ST_OPENING;
        ST_OPENING: begin
          if (travel_to)      state_n = ST_FAULT;
          else if (aberto_s)  state_n = ST_OPEN;
          else if (btn_pulse) begin
            state_n    = ST_STOPPED;
            last_dir_n = DIR_OPEN;
          end
        end
        ST_OPEN:    if (cnt == AUTO_LIM || btn_pulse) state_n = ST_CLOSING;
        ST_CLOSING: begin
          if (travel_to)      state_n = ST_FAULT;
          else if (fechado_s) state_n = ST_CLOSED;
          else if (obst_s)    state_n = ST_OPENING;
          else if (btn_pulse) begin
            state_n    = ST_STOPPED;
            last_dir_n = DIR_CLOSE;
          end
        end
        ST_STOPPED: begin
          if (fechado_s)      state_n = ST_CLOSED;
          else if (aberto_s)  state_n = ST_OPEN;
          else if (btn_pulse) state_n = (last_dir == DIR_OPEN) ? ST_CLOSING : ST_OPENING;
        end
        ST_FAULT:   state_n = ST_FAULT;
        default:    state_n = ST_FAULT;
      endcase
    end
  end

  // One phase counter: dead time, then motor-on travel time, or auto-close.
  always_comb begin
    cnt_n  = cnt;
    dead_n = dead;
    if (state_n != state) begin
      cnt_n  = '0;
      dead_n = DEAD_SKIP;
    end else begin
      case (state)
        ST_OPENING, ST_CLOSING: begin
          if (!dead && cnt == DEAD_LAST) begin
            dead_n = 1'b1;
            cnt_n  = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        ST_OPEN: cnt_n = obst_s ? '0 : cnt_inc;
        default: cnt_n = '0;
      endcase
    end
  end

  always_comb begin
    drv_n              = drv;
    motor_n            = is_moving(state_n) && dead_n;
    drv_n.motor        = motor_n;
    drv_n.sentido      = motor_n ? ((state_n == ST_OPENING) ? DIR_OPEN : DIR_CLOSE) : drv.sentido;
    drv_n.led_verde    = (state_n == ST_OPENING) || (state_n == ST_FAULT);
    drv_n.led_vermelho = (state_n == ST_CLOSING) || (state_n == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state    <= ST_STOPPED;
      last_dir <= DIR_OPEN;
      cnt      <= '0;
      dead     <= 1'b0;
      drv      <= '0;
    end else begin
      state    <= state_n;
      last_dir <= last_dir_n;
      cnt      <= cnt_n;
      dead     <= dead_n;
      drv      <= drv_n;
    end
  end

  assign motor        = drv.motor;
  assign sentido      = drv.sentido;
  assign led_verde    = drv.led_verde;
  assign led_vermelho = drv.led_vermelho;
  assign estado       = state;

endmodule

// File: tb/tb_gate_motor_controller.sv
// Bench for gate_motor_controller with shortened timing constants; table of
// input/expected-output steps through a scoreboard queue plus corner sequences.
module tb_gate_motor_controller;

  localparam logic [2:0] CLOSED = 3'd0, OPENING = 3'd1, OPEN = 3'd2,
                         CLOSING = 3'd3, STOPPED = 3'd4, FAULT = 3'd5;

  logic       clk = 1'b0, rst_n = 1'b1;
  logic       botao = 1'b0, aberto = 1'b0, fechado = 1'b0, obstaculo = 1'b0;
  logic       motor, sentido, led_verde, led_vermelho;
  logic [2:0] estado;

  gate_motor_controller #(
    .CNT_W(8), .DEBOUNCE_CYC(4), .DEAD_CYC(2), .TRAVEL_CYC(50), .AUTO_CLOSE_CYC(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .botao(botao), .aberto(aberto), .fechado(fechado),
    .obstaculo(obstaculo), .motor(motor), .sentido(sentido), .led_verde(led_verde),
    .led_vermelho(led_vermelho), .estado(estado)
  );

  always #5 clk = ~clk;

  // Drive inputs, wait (up to hi cycles) for state st, require arrival no
  // earlier than lo, wait hold more cycles, then compare all outputs.
  typedef struct {
    logic b, a, f, o;
    int lo, hi, hold;
    logic [2:0] st;
    logic m, s, lv, lr;
    string name;
  } vec_t;

  vec_t tbl[13];
  vec_t exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(input logic b, a, f, o, input int lo, hi, hold,
                              input logic [2:0] st, input logic m, s, lv, lr, input string name);
    vec_t v;
    v.b = b; v.a = a; v.f = f; v.o = o; v.lo = lo; v.hi = hi; v.hold = hold;
    v.st = st; v.m = m; v.s = s; v.lv = lv; v.lr = lr; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input bit ok, input string got, input string want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", name, got, want);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int first;
    botao = v.b; aberto = v.a; fechado = v.f; obstaculo = v.o;
    exp_q.push_back(v);
    first = 0;
    for (int n = 1; n <= v.hi; n++) begin
      @(negedge clk);
      if (estado == v.st) begin
        first = n;
        break;
      end
    end
    repeat (v.hold) @(negedge clk);
    e = exp_q.pop_front();
    check(e.name,
          first != 0 && first >= e.lo && estado == e.st && motor == e.m &&
          sentido == e.s && led_verde == e.lv && led_vermelho == e.lr,
          $sformatf("arrive=%0d st=%0d m=%b s=%b lv=%b lr=%b",
                    first, estado, motor, sentido, led_verde, led_vermelho),
          $sformatf("arrive=%0d..%0d st=%0d m=%b s=%b lv=%b lr=%b",
                    e.lo, e.hi, e.st, e.m, e.s, e.lv, e.lr));
  endtask

  task automatic do_reset(input logic a, input logic f);
    rst_n = 1'b0; botao = 1'b0; obstaculo = 1'b0; aberto = a; fechado = f;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int first;
    bit mot_seen;
    logic [2:0] st1;

    tbl[0]  = mk(1, 0, 1, 0,  6,  8, 0, OPENING, 0, 0, 1, 0, "press_open");
    tbl[1]  = mk(1, 0, 1, 0,  1,  1, 0, OPENING, 0, 0, 1, 0, "open_dead_time");
    tbl[2]  = mk(1, 0, 1, 0,  1,  1, 0, OPENING, 1, 1, 1, 0, "open_motor_on");
    tbl[3]  = mk(0, 0, 0, 0,  1,  1, 3, OPENING, 1, 1, 1, 0, "held_btn_one_pulse");
    tbl[4]  = mk(0, 1, 0, 0,  2,  4, 0, OPEN,    0, 1, 0, 0, "reach_open");
    tbl[5]  = mk(0, 1, 0, 0, 19, 22, 0, CLOSING, 0, 1, 0, 1, "auto_close");
    tbl[6]  = mk(0, 0, 0, 0,  1,  1, 0, CLOSING, 0, 1, 0, 1, "close_dead_time");
    tbl[7]  = mk(0, 0, 0, 0,  1,  1, 0, CLOSING, 1, 0, 0, 1, "close_motor_on");
    tbl[8]  = mk(0, 0, 0, 1,  2,  4, 0, OPENING, 0, 0, 1, 0, "obstacle_reversal");
    tbl[9]  = mk(0, 0, 0, 0,  1,  1, 0, OPENING, 0, 0, 1, 0, "reversal_dead_time");
    tbl[10] = mk(0, 0, 0, 0,  1,  1, 0, OPENING, 1, 1, 1, 0, "reversal_motor_on");
    tbl[11] = mk(0, 0, 0, 0, 49, 53, 0, FAULT,   0, 1, 1, 1, "travel_timeout");
    tbl[12] = mk(1, 0, 0, 0,  1,  1, 12, FAULT,  0, 1, 1, 1, "fault_sticky");

    // Reset with the gate closed.
    fechado = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          estado == STOPPED && !motor && !sentido && !led_verde && !led_vermelho,
          $sformatf("st=%0d m=%b s=%b lv=%b lr=%b", estado, motor, sentido, led_verde, led_vermelho),
          "st=4 m=0 s=0 lv=0 lr=0");
    rst_n = 1'b1;
    first = 0; mot_seen = 0; st1 = 3'd7;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (n == 1) st1 = estado;
      if (motor) mot_seen = 1;
      if (estado == CLOSED) begin
        first = n;
        break;
      end
    end
    check("reset_to_closed", first != 0 && st1 == STOPPED && !mot_seen,
          $sformatf("arrive=%0d first_st=%0d motor_seen=%b", first, st1, mot_seen),
          "arrive=1..3 first_st=4 motor_seen=0");

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    // Auto-close restarts when the photocell is blocked in OPEN.
    do_reset(1'b1, 1'b0);
    run_vec(mk(0, 1, 0, 0, 1, 3, 0, OPEN, 0, 0, 0, 0, "reset_to_open"));
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (estado == CLOSING) begin
        first = n;
        break;
      end
      obstaculo = (n == 10);
    end
    obstaculo = 1'b0;
    check("obstacle_restarts_autoclose", first >= 30 && first <= 36,
          $sformatf("arrive=%0d", first), "arrive=30..36");

    // Stop while closing, then resume in the opposite direction.
    run_vec(mk(1, 0, 0, 0, 6, 8, 0, STOPPED, 0, 0, 0, 0, "btn_stop_closing"));
    run_vec(mk(0, 0, 0, 0, 1, 1, 10, STOPPED, 0, 0, 0, 0, "stopped_holds"));
    run_vec(mk(1, 0, 0, 0, 6, 8, 0, OPENING, 0, 0, 1, 0, "resume_opening"));
    run_vec(mk(0, 0, 0, 0, 1, 1, 2, OPENING, 1, 1, 1, 0, "resume_motor_on"));
    run_vec(mk(0, 1, 0, 0, 2, 4, 0, OPEN, 0, 1, 0, 0, "reopen"));

    // Short button glitch, then both limit sensors at once.
    botao = 1'b1;
    repeat (3) @(negedge clk);
    botao = 1'b0;
    run_vec(mk(0, 1, 0, 0, 1, 1, 8, OPEN, 0, 1, 0, 0, "glitch_ignored"));
    run_vec(mk(0, 1, 1, 0, 2, 4, 0, FAULT, 0, 1, 1, 1, "sensor_conflict"));

    // Reset while travelling: motor drops without a clock, STOPPED resolution follows.
    do_reset(1'b0, 1'b1);
    run_vec(mk(0, 0, 1, 0, 1, 3, 0, CLOSED, 0, 0, 0, 0, "reset_closed_again"));
    run_vec(mk(1, 0, 1, 0, 6, 8, 2, OPENING, 1, 1, 1, 0, "open_for_reset"));
    #2 rst_n = 1'b0;
    #1;
    check("async_motor_drop", !motor && estado == STOPPED,
          $sformatf("m=%b st=%0d", motor, estado), "m=0 st=4");
    @(negedge clk);
    botao = 1'b0; fechado = 1'b0; aberto = 1'b0;
    rst_n = 1'b1;
    run_vec(mk(0, 0, 0, 0, 1, 1, 8, STOPPED, 0, 0, 0, 0, "stopped_mid_travel"));
    run_vec(mk(1, 0, 0, 0, 6, 8, 0, CLOSING, 0, 0, 0, 1, "stopped_btn_closes"));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
